// File: rtl/scan_deserializer.sv
// Receive side of an 8-line time-multiplexed scan link: drives the remote
// selector address, samples the serial bit each scan tick, publishes frames.
module scan_deserializer #(
  parameter int ADDR_W    = 3,
  parameter bit INVERT_IN = 1'b0,
  localparam int LINES    = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              sync,
  input  logic              sdata,
  output logic [ADDR_W-1:0] addr,
  output logic [LINES-1:0]  q,
  output logic              valid,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINES - 1);

  logic             s;
  logic [LINES-1:0] shift;
  logic [LINES-1:0] frame_word;

  assign s = sdata ^ INVERT_IN;

  // The last line's sample goes straight into the published word.
  always_comb begin
    frame_word            = shift;
    frame_word[LINES-1]   = s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      shift     <= '0;
      q         <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else if (sync) begin
      addr      <= '0;
      shift     <= '0;
      valid     <= 1'b0;
      frame_err <= (addr != '0);
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (ce) begin
        shift[addr] <= s;
        addr        <= addr + ADDR_W'(1);
        if (addr == LAST_ADDR) begin
          q     <= frame_word;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_deserializer.sv
// Bench for scan_deserializer: two instances (true and inverted serial input)
// fed from a model selector, checked against a frame-level model every cycle.
module tb_scan_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       sync;
  logic [7:0] d_lines;

  logic       sdata0, sdata1;
  logic [2:0] addr0, addr1;
  logic [7:0] q0, q1;
  logic       valid0, valid1;
  logic       err0, err1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Frame-level model state
  int       m_pos;
  bit [7:0] m_bits;
  bit [7:0] m_q;
  bit       m_valid;
  bit       m_err;

  always #5 clk = ~clk;

  // Remote selector: Y on dut0's wire, Y_N on dut1's wire
  assign sdata0 = d_lines[addr0];
  assign sdata1 = ~d_lines[addr1];

  scan_deserializer #(.ADDR_W(3), .INVERT_IN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .sync(sync), .sdata(sdata0),
    .addr(addr0), .q(q0), .valid(valid0), .frame_err(err0)
  );

  scan_deserializer #(.ADDR_W(3), .INVERT_IN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .sync(sync), .sdata(sdata1),
    .addr(addr1), .q(q1), .valid(valid1), .frame_err(err1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The model collects the true line value per frame position and publishes
  // after the eighth sample; sync restarts the frame.
  always @(posedge clk) begin
    if (reset) begin
      m_pos = 0; m_q = 8'h00; m_valid = 1'b0; m_err = 1'b0;
    end else if (sync) begin
      m_err = (m_pos != 0); m_pos = 0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b0; m_err = 1'b0;
      if (ce) begin
        m_bits[m_pos] = d_lines[m_pos];
        m_pos++;
        if (m_pos == 8) begin
          m_q = m_bits; m_valid = 1'b1; m_pos = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("addr0", 32'(addr0), 32'(m_pos));
      checkOutput("q0", 32'(q0), 32'(m_q));
      checkOutput("valid0", 32'(valid0), 32'(m_valid));
      checkOutput("frame_err0", 32'(err0), 32'(m_err));
      checkOutput("addr1", 32'(addr1), 32'(m_pos));
      checkOutput("q1", 32'(q1), 32'(m_q));
      checkOutput("valid1", 32'(valid1), 32'(m_valid));
      checkOutput("frame_err1", 32'(err1), 32'(m_err));
    end
  end

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; sync = 1'b0; d_lines = 8'h00;
    applyStimulus(2);
    cmp_en = 1'b1;
    reset = 1'b0;
    checkOutput("reset_addr", 32'(addr0), 32'd0);
    checkOutput("reset_q", 32'(q0), 32'h00);
    checkOutput("reset_valid", 32'(valid0), 32'd0);

    // Continuous scan of 8'hA5
    d_lines = 8'hA5; ce = 1'b1;
    applyStimulus(7);
    checkOutput("a5_addr7", 32'(addr0), 32'd7);
    checkOutput("a5_novalid_yet", 32'(valid0), 32'd0);
    applyStimulus(1);
    checkOutput("a5_q", 32'(q0), 32'hA5);
    checkOutput("a5_valid", 32'(valid0), 32'd1);
    applyStimulus(1);
    checkOutput("a5_valid_pulse", 32'(valid0), 32'd0);
    applyStimulus(7);
    checkOutput("a5_second_valid", 32'(valid0), 32'd1);

    // Inverted input path
    d_lines = 8'h3C;
    applyStimulus(8);
    checkOutput("inv_q1", 32'(q1), 32'h3C);
    checkOutput("inv_q0", 32'(q0), 32'h3C);

    // ce active one cycle in three
    d_lines = 8'h81;
    for (int i = 0; i < 8; i++) begin
      ce = 1'b1;
      applyStimulus(1);
      checkOutput("slow_valid", 32'(valid0), (i == 7) ? 32'd1 : 32'd0);
      ce = 1'b0;
      applyStimulus(1);
      checkOutput("slow_addr_hold", 32'(addr0), 32'((i + 1) % 8));
      checkOutput("slow_valid_pulse", 32'(valid0), 32'd0);
      applyStimulus(1);
    end
    checkOutput("slow_q", 32'(q0), 32'h81);

    // Mid-frame sync at addr 5
    d_lines = 8'hF0; ce = 1'b1;
    applyStimulus(5);
    checkOutput("sync5_addr", 32'(addr0), 32'd5);
    ce = 1'b0; sync = 1'b1;
    applyStimulus(1);
    checkOutput("sync5_err", 32'(err0), 32'd1);
    checkOutput("sync5_addr0", 32'(addr0), 32'd0);
    checkOutput("sync5_q_hold", 32'(q0), 32'h81);
    checkOutput("sync5_novalid", 32'(valid0), 32'd0);
    sync = 1'b0;
    applyStimulus(1);
    checkOutput("sync5_err_pulse", 32'(err0), 32'd0);
    d_lines = 8'h0F; ce = 1'b1;
    applyStimulus(8);
    checkOutput("after_sync_q", 32'(q0), 32'h0F);
    checkOutput("after_sync_valid", 32'(valid0), 32'd1);

    // sync colliding with the last-line tick, then sync at addr 0
    d_lines = 8'hFF;
    applyStimulus(7);
    sync = 1'b1;
    applyStimulus(1);
    checkOutput("sync7_novalid", 32'(valid0), 32'd0);
    checkOutput("sync7_err", 32'(err0), 32'd1);
    checkOutput("sync7_q_hold", 32'(q0), 32'h0F);
    ce = 1'b0;
    applyStimulus(1);
    checkOutput("sync0_silent", 32'(err0), 32'd0);
    sync = 1'b0;

    // Reset mid-frame
    d_lines = 8'hA5; ce = 1'b1;
    applyStimulus(8);
    checkOutput("pre_reset_q", 32'(q0), 32'hA5);
    applyStimulus(4);
    checkOutput("pre_reset_addr", 32'(addr0), 32'd4);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("rst_q", 32'(q0), 32'h00);
    checkOutput("rst_addr", 32'(addr0), 32'd0);
    checkOutput("rst_valid", 32'(valid0), 32'd0);
    checkOutput("rst_err", 32'(err0), 32'd0);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("post_rst_addr", 32'(addr0), 32'd1);
    ce = 1'b0;
    applyStimulus(2);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
